// File: rtl/sindoku_btn_conditioner.sv
// Pushbutton conditioner for the sindoku core: per-button 2-FF sync, debounce FSM and
// hold-to-repeat timer producing registered one-cycle pulses plus a debounced level.

module sindoku_btn_chan #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 12500000,
  parameter bit REP_EN          = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_btn,
  output logic o_pulse,
  output logic o_held
);
  localparam int MAXP = (DEBOUNCE_CYCLES > REPEAT_DELAY)
                        ? ((DEBOUNCE_CYCLES > REPEAT_RATE) ? DEBOUNCE_CYCLES : REPEAT_RATE)
                        : ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam int CW = $clog2(MAXP + 1);
  localparam logic [CW-1:0] DB_C  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RD_C  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RR_C  = CW'(REPEAT_RATE);
  localparam logic [CW-1:0] C_MAX = '1;
  localparam logic [CW-1:0] C_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, REL_WAIT} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_s1, r_s2;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CW-1:0] r_rpt, w_rpt_nxt, w_rpt_inc;
  logic          r_phase, w_phase_nxt;
  logic          r_pulse, w_pulse_nxt;
  logic          r_held, w_held_nxt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rpt   <= '0;
      r_phase <= 1'b0;
      r_pulse <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rpt   <= w_rpt_nxt;
      r_phase <= w_phase_nxt;
      r_pulse <= w_pulse_nxt;
      r_held  <= w_held_nxt;
    end
  end

  // r_phase: 0 = waiting out the initial delay, 1 = steady repeat cadence
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rpt_nxt   = r_rpt;
    w_phase_nxt = r_phase;
    w_pulse_nxt = 1'b0;
    w_cnt_inc   = (r_cnt == C_MAX) ? r_cnt : r_cnt + C_ONE;
    w_rpt_inc   = (r_rpt == C_MAX) ? r_rpt : r_rpt + C_ONE;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (r_s2) begin
          w_state_nxt = PRESS_DB;
          w_cnt_nxt   = C_ONE;
        end
      end
      PRESS_DB: begin
        if (!r_s2) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= DB_C) begin
          w_state_nxt = PRESSED;
          w_pulse_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_rpt_nxt   = '0;
          w_phase_nxt = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      PRESSED: begin
        if (!r_s2) begin
          w_state_nxt = REL_WAIT;
          w_cnt_nxt   = C_ONE;
          w_rpt_nxt   = '0;
          w_phase_nxt = 1'b0;
        end else if (REP_EN) begin
          w_rpt_nxt = w_rpt_inc;
          if ((!r_phase && w_rpt_inc == RD_C) || (r_phase && w_rpt_inc == RR_C)) begin
            w_pulse_nxt = 1'b1;
            w_rpt_nxt   = '0;
            w_phase_nxt = 1'b1;
          end
        end
      end
      REL_WAIT: begin
        if (r_s2) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_rpt_nxt   = '0;
          w_phase_nxt = 1'b0;
        end else if (r_cnt >= DB_C) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_rpt_nxt   = '0;
        w_phase_nxt = 1'b0;
      end
    endcase
    w_held_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == REL_WAIT);
  end

  assign o_pulse = r_pulse;
  assign o_held  = r_held;
endmodule

module sindoku_btn_conditioner #(
  parameter int               N_BTN           = 5,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               REPEAT_DELAY    = 50000000,
  parameter int               REPEAT_RATE     = 12500000,
  parameter logic [N_BTN-1:0] REPEAT_EN       = 5'b01111
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] BtnIn,
  output logic [N_BTN-1:0] Pulse,
  output logic [N_BTN-1:0] Held
);
  for (genvar k = 0; k < N_BTN; k++) begin : g_btn
    sindoku_btn_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REP_EN         (REPEAT_EN[k])
    ) u_chan (
      .Clk    (Clk),
      .Reset  (Reset),
      .i_btn  (BtnIn[k]),
      .o_pulse(Pulse[k]),
      .o_held (Held[k])
    );
  end
endmodule

// File: tb/tb_sindoku_btn_conditioner.sv
// Directed + randomized bench for sindoku_btn_conditioner with a sample-history reference model.

module tb_sindoku_btn_conditioner;
  localparam int          NB  = 5;
  localparam int          DB  = 4;
  localparam int          RD  = 10;
  localparam int          RR  = 5;
  localparam logic [4:0]  REN = 5'b01111;

  logic          Clk, Reset;
  logic [NB-1:0] BtnIn, Pulse, Held;

  sindoku_btn_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_EN(REN)
  ) dut (
    .Clk(Clk), .Reset(Reset), .BtnIn(BtnIn), .Pulse(Pulse), .Held(Held)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  int pcnt [NB];
  int first[NB];
  int both;

  // reference model state: synchronizer image plus run lengths of the synchronized level
  logic [NB-1:0] m_s1, m_s2, exp_pulse, exp_held, last_s;
  int ones[NB], zeros[NB], since[NB];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic [NB-1:0] b, input logic r);
    logic [NB-1:0] s;
    logic prev;
    if (r) begin
      m_s1 = '0; m_s2 = '0; exp_pulse = '0; exp_held = '0; last_s = '0;
      for (int k = 0; k < NB; k++) begin ones[k] = 0; zeros[k] = 0; since[k] = 0; end
      return;
    end
    s = m_s2; m_s2 = m_s1; m_s1 = b;
    exp_pulse = '0;
    for (int k = 0; k < NB; k++) begin
      prev = last_s[k];
      last_s[k] = s[k];
      if (s[k]) begin ones[k]++; zeros[k] = 0; end
      else begin zeros[k]++; ones[k] = 0; end
      if (!exp_held[k]) begin
        if (ones[k] == DB + 1) begin
          exp_pulse[k] = 1'b1; exp_held[k] = 1'b1; since[k] = 0;
        end
      end else if (s[k]) begin
        if (!prev) since[k] = 0;
        else begin
          since[k]++;
          if (REN[k] && since[k] >= RD && ((since[k] - RD) % RR) == 0) exp_pulse[k] = 1'b1;
        end
      end else if (zeros[k] == DB + 1) begin
        exp_held[k] = 1'b0;
      end
    end
  endtask

  task automatic clr_obs();
    for (int k = 0; k < NB; k++) begin pcnt[k] = 0; first[k] = -1; end
    both = 0;
  endtask

  task automatic step();
    @(posedge Clk);
    cyc++;
    model_edge(BtnIn, Reset);
    #1;
    chk("pulse", 32'(Pulse), 32'(exp_pulse));
    chk("held",  32'(Held),  32'(exp_held));
    for (int k = 0; k < NB; k++)
      if (Pulse[k] === 1'b1) begin
        pcnt[k]++;
        if (first[k] < 0) first[k] = cyc;
      end
    if (Pulse[0] === 1'b1 && Pulse[4] === 1'b1) both++;
  endtask

  initial begin
    int t0;
    logic [5:0] bounce;
    Reset = 1'b1; BtnIn = '0;
    m_s1 = '0; m_s2 = '0; exp_pulse = '0; exp_held = '0; last_s = '0;
    clr_obs();
    repeat (3) step();
    chk("rst_pulse", 32'(Pulse), 32'd0);
    chk("rst_held",  32'(Held),  32'd0);
    Reset = 1'b0;
    repeat (2) step();

    // 1: single press, latency and single pulse
    clr_obs();
    BtnIn = 5'b00001; t0 = cyc + 1;
    repeat (12) step();
    chk("t1_held", 32'(Held[0]), 32'd1);
    BtnIn = '0;
    repeat (12) step();
    chk("t1_cnt", pcnt[0], 1);
    chk("t1_lat", first[0] - t0, 6);
    chk("t1_rel", 32'(Held[0]), 32'd0);

    // 2: bounce never completes debounce
    clr_obs();
    bounce = 6'b011011;
    for (int i = 0; i < 6; i++) begin BtnIn = {2'b00, bounce[i], 2'b00}; step(); end
    BtnIn = '0;
    repeat (10) step();
    chk("t2_cnt",  pcnt[2], 0);
    chk("t2_held", 32'(Held[2]), 32'd0);

    // 3: repeat on D, none on C
    clr_obs();
    BtnIn = 5'b01000; t0 = cyc + 1;
    repeat (40) step();
    BtnIn = '0;
    repeat (12) step();
    chk("t3_d_cnt", pcnt[3], 7);
    chk("t3_d_lat", first[3] - t0, 6);
    clr_obs();
    BtnIn = 5'b10000;
    repeat (40) step();
    BtnIn = '0;
    repeat (12) step();
    chk("t3_c_cnt", pcnt[4], 1);

    // 4: release bounce keeps the button held
    clr_obs();
    BtnIn = 5'b00010;
    repeat (8) step();
    BtnIn = '0;
    repeat (2) step();
    BtnIn = 5'b00010;
    repeat (8) step();
    chk("t4_held", 32'(Held[1]), 32'd1);
    chk("t4_cnt",  pcnt[1], 1);
    BtnIn = '0;
    repeat (12) step();
    chk("t4_rel", 32'(Held[1]), 32'd0);

    // 5: simultaneous presses
    clr_obs();
    BtnIn = 5'b10001;
    repeat (10) step();
    BtnIn = '0;
    repeat (12) step();
    chk("t5_both", both, 1);
    chk("t5_r",    pcnt[0], 1);
    chk("t5_c",    pcnt[4], 1);

    // 6: reset mid-hold, then a fresh press
    BtnIn = 5'b00001;
    repeat (9) step();
    Reset = 1'b1;
    step();
    chk("t6_pulse", 32'(Pulse), 32'd0);
    chk("t6_held",  32'(Held),  32'd0);
    Reset = 1'b0;
    clr_obs(); t0 = cyc + 1;
    repeat (10) step();
    chk("t6_lat", first[0] - t0, 6);
    chk("t6_cnt", pcnt[0], 1);
    BtnIn = '0;
    repeat (12) step();

    // random: slowly toggling buttons with rare resets
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < NB; k++)
        if ($urandom_range(0, 19) == 0) BtnIn[k] = ~BtnIn[k];
      Reset = ($urandom_range(0, 599) == 0);
      step();
    end
    Reset = 1'b0; BtnIn = '0;
    repeat (12) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
